// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: queues {op,count} commands, drives
// registered J/K for count+1 cycles each, and shadows the flop's Q to flag
// any divergence from the fed-back value.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     q_fb,
  output logic                     q_model,
  output logic                     mismatch
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = 2 + CNT_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             r_j;
  logic             r_k;
  logic             w_j_nxt;
  logic             w_k_nxt;
  logic             r_q;
  logic             r_mismatch;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_head;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_push    = cmd_valid && !w_full && !flush;
  assign w_head    = r_mem[r_rd_ptr];

  assign cmd_ready = !w_full;
  assign J         = r_j;
  assign K         = r_k;
  assign busy      = (r_state == RUN);
  assign level     = r_level;
  assign q_model   = r_q;
  assign mismatch  = r_mismatch;

  // FIFO storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_count};
    end
  end

  // FIFO pointers and occupancy; flush empties the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sequencer state, J/K drive and remaining-repeat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_rem   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Next-state: pop a command whenever the current one is exhausted
  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_rem_nxt   = r_rem;
    w_pop       = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
      w_j_nxt     = 1'b0;
      w_k_nxt     = 1'b0;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_j_nxt = 1'b0;
          w_k_nxt = 1'b0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_j_nxt     = w_head[EW-1];
            w_k_nxt     = w_head[EW-2];
            w_rem_nxt   = w_head[CNT_W-1:0];
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (r_rem != '0) begin
            w_rem_nxt = r_rem - CNT_W'(1);
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_j_nxt   = w_head[EW-1];
            w_k_nxt   = w_head[EW-2];
            w_rem_nxt = w_head[CNT_W-1:0];
          end else begin
            w_j_nxt     = 1'b0;
            w_k_nxt     = 1'b0;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Shadow of the flop's Q and sticky divergence flag (flush leaves both alone)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q        <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      case ({r_j, r_k})
        2'b00:   r_q <= r_q;
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        default: r_q <= ~r_q;
      endcase
      if (q_fb != r_q) r_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Bench for jk_cmd_sequencer: a behavioural JK flop closes the q_fb loop,
// a per-cycle J/K scoreboard checks ordering and timing, plus directed corners.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic             J;
  logic             K;
  logic             busy;
  logic [2:0]       level;
  logic             q_fb;
  logic             q_model;
  logic             mismatch;

  logic             flop_q;
  logic             inv;

  int n_tests = 0;
  int n_fail  = 0;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count),
    .J(J), .K(K), .busy(busy), .level(level),
    .q_fb(q_fb), .q_model(q_model), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // The JK flop being driven, sharing clk/rst with the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flop_q <= 1'b0;
    else begin
      case ({J, K})
        2'b00:   flop_q <= flop_q;
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        default: flop_q <= ~flop_q;
      endcase
    end
  end
  assign q_fb = flop_q ^ inv;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: one expected {J,K} per cycle the op should be driven
  logic [1:0] sb[$];
  int         last_push_n = 0;
  int         busy_cyc = 0;
  int         max_level = 0;
  logic       prev_busy = 1'b0;

  always @(posedge clk) begin
    last_push_n = 0;
    if (rst || flush) sb.delete();
    else if (cmd_valid && cmd_ready) begin
      for (int i = 0; i <= int'(cmd_count); i++) sb.push_back(cmd_op);
      last_push_n = int'(cmd_count) + 1;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (busy) begin
        busy_cyc++;
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("jk_run", 32'({J, K}), 32'(e));
        end
      end else begin
        chk("jk_idle", 32'({J, K}), 0);
        if (prev_busy) chk("no_gap", 32'(sb.size() <= last_push_n), 1);
      end
      if (int'(level) > max_level) max_level = int'(level);
      if (int'(level) == DEPTH) chk("ready_full", 32'(cmd_ready), 0);
      prev_busy = busy;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present a command and hold valid until it is accepted
  task automatic push(input logic [1:0] op, input logic [CNT_W-1:0] cnt);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_accept", 32'(n < 100), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy || level != 0) && n < 500);
    chk("idle_reached", 32'(n < 500), 1);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             q_end;
  } vec_t;

  vec_t       tbl[8];
  logic [1:0] bp_ops[6];
  logic       tog_exp[4];
  int         b0;

  initial begin
    tbl[0] = '{2'b10, 4'd0,  1'b1};
    tbl[1] = '{2'b00, 4'd2,  1'b1};
    tbl[2] = '{2'b01, 4'd1,  1'b0};
    tbl[3] = '{2'b11, 4'd3,  1'b0};
    tbl[4] = '{2'b11, 4'd2,  1'b1};
    tbl[5] = '{2'b01, 4'd0,  1'b0};
    tbl[6] = '{2'b10, 4'd15, 1'b1};
    tbl[7] = '{2'b11, 4'd0,  1'b0};
    bp_ops  = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b11, 2'b10};
    tog_exp = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; inv = 1'b0;
    #1;
    chk("rst_jk", 32'({J, K}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_q", 32'(q_model), 0);
    chk("rst_mismatch", 32'(mismatch), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_after_rst", 32'(cmd_ready), 1);

    // Single commands one at a time
    for (int i = 0; i < 8; i++) begin
      b0 = busy_cyc;
      push(tbl[i].op, tbl[i].cnt);
      wait_idle();
      chk("tbl_q_end", 32'(q_model), 32'(tbl[i].q_end));
      chk("tbl_run_len", 32'(busy_cyc - b0), 32'(int'(tbl[i].cnt) + 1));
    end
    chk("tbl_mismatch", 32'(mismatch), 0);

    // Toggle run from Q=0: q_model 1,0,1,0
    push(2'b11, 4'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("toggle_q", 32'(q_model), 32'(tog_exp[i]));
    end
    wait_idle();
    chk("toggle_mismatch", 32'(mismatch), 0);

    // Back-to-back with backpressure: long head fills the FIFO behind it
    b0 = busy_cyc;
    push(2'b10, 4'd7);
    for (int i = 0; i < 6; i++) push(bp_ops[i], 4'd1);
    wait_idle();
    chk("bp_reached_full", 32'(max_level), 32'(DEPTH));
    chk("bp_run_len", 32'(busy_cyc - b0), 20);
    chk("bp_sb_drained", 32'(sb.size()), 0);

    // Flush in RUN with three queued; command offered in the flush cycle is dropped
    push(2'b10, 4'd8);
    push(2'b01, 4'd0);
    push(2'b11, 4'd0);
    push(2'b00, 4'd0);
    chk("flush_pre_level", 32'(level), 3);
    chk("flush_pre_busy", 32'(busy), 1);
    flush = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 4'd0;
    chk("ready_in_flush", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    chk("flush_jk", 32'({J, K}), 0);
    chk("flush_level", 32'(level), 0);
    chk("flush_busy", 32'(busy), 0);
    repeat (4) @(posedge clk); #1;
    chk("flush_dropped", 32'({busy, level}), 0);

    // Mismatch: one inverted feedback cycle; sticky through flush
    chk("mm_before", 32'(mismatch), 0);
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    chk("mm_set", 32'(mismatch), 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("mm_after_flush", 32'(mismatch), 1);

    // Asynchronous reset mid-run with level=2
    push(2'b10, 4'd5);
    push(2'b01, 4'd0);
    push(2'b11, 4'd0);
    chk("rr_pre_level", 32'(level), 2);
    chk("rr_pre_busy", 32'(busy), 1);
    chk("rr_pre_q", 32'(q_model), 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_jk", 32'({J, K}), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_level", 32'(level), 0);
    chk("rr_q", 32'(q_model), 0);
    chk("rr_mismatch", 32'(mismatch), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rr_ready", 32'(cmd_ready), 1);
    repeat (3) @(posedge clk); #1;
    chk("rr_quiet", 32'({busy, q_model, mismatch}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream command stage for the JK flip-flop.
- Accepts hold/reset/set/toggle commands with a repeat count over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered J/K to the flop for count+1 cycles per command.
- Keeps a cycle-exact model of the flop's Q, checks it against the flop's fed-back Q and flags any divergence.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- CNT_W, 4: width of the repeat-count field.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of queue and sequencer.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  {J,K} code: 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_count  input  CNT_W  extra cycles; the op is driven count+1 cycles.
- J  output  1  registered J to the flop.
- K  output  1  registered K to the flop.
- busy  output  1  high while in RUN.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- q_fb  input  1  Q fed back from the flop (same clk/rst domain).
- q_model  output  1  predicted flop Q.
- mismatch  output  1  sticky: q_fb differed from q_model.

Behaviour:
- Reset (async, rst=1): FIFO empty, level=0, state IDLE, J=K=0, busy=0, q_model=0, mismatch=0. cmd_ready=1 once rst deasserts.

Handshake:
- cmd_ready = !full, combinational from registered level.
- Push on posedge when cmd_valid && cmd_ready.
- No push when full, even if a pop occurs in the same cycle.
- Command fields are captured only on push.

FSM, two states:
- IDLE:
  - J=K=0.
  - If FIFO is non-empty at a posedge: pop head, load {J,K}<=op, rem<=count, go to RUN.
  - A command pushed at edge e is popped at edge e+1, so J/K show the op after edge e+1.
- RUN:
  - If rem!=0: rem<=rem-1, J/K held.
  - If rem==0 and FIFO non-empty: pop the next command and load it at the same edge (no gap cycle between commands).
  - If rem==0 and FIFO empty: J=K<=00, go to IDLE.
- busy = (state==RUN).

Level and FIFO:
- Push and pop in the same edge leave level unchanged.
- Read/write pointers wrap modulo DEPTH.

Q model:
- Updated at every posedge with the same function the flop applies to the current J/K outputs: 00 hold, 01 clear, 10 set, 11 invert.
- The flop samples identical J/K at the same edge, so q_model equals the expected flop Q every cycle.

Mismatch:
- Set at a posedge when q_fb != q_model.
- Cleared only by rst. Unaffected by flush.

Flush (synchronous, highest priority after rst):
- Empties the FIFO, forces IDLE, J=K<=0, rem<=0.
- q_model and mismatch keep updating normally.
- cmd_valid in the flush cycle is dropped. cmd_ready still shows !full in that cycle.

Reset mid-operation:
- All state returns to reset values immediately.
- The flop is reset by the same rst, so q_model=0 stays consistent with it.

Count rules:
- count=0 drives the op for 1 cycle.
- count=2^CNT_W-1 drives it for 2^CNT_W cycles.
- No overflow is possible.

Test Plan:
- Reset: assert rst mid-run (RUN, level=2) -> J=K=0, busy=0, level=0, q_model=0, mismatch=0, all asynchronously; cmd_ready=1 after release.
- Single set: push op=10, count=0 into an empty queue at edge e -> J=1,K=0 only between edges e+1 and e+2; q_fb/q_model=1 after e+2, then J=K=0 and busy=0.
- Toggle run: after Q=0, push op=11, count=3 -> J=K=1 for 4 cycles; q_model sequence 1,0,1,0; mismatch stays 0 with the real flop attached.
- Back-to-back plus backpressure: hold cmd_valid with 6 commands (DEPTH=4), each count=1 -> cmd_ready drops at level=4; every command is executed in order, each for exactly 2 cycles, with no idle gap between commands.
- Flush: flush while in RUN with level=3 -> next cycle J=K=0, level=0, busy=0; a cmd_valid asserted in the flush cycle is not executed.
- Mismatch: force q_fb inverted for one cycle -> mismatch=1 from the next edge and it stays 1 through flush; only rst clears it.
